// File: rtl/lsu_burst_engine.sv
// lsu_burst_engine
//   Multi-cycle load/store sequencer between a 512-bit register file and a
//   32-bit-word data memory. A store streams one wide register out as WORDS
//   consecutive memory writes. A load reads WORDS consecutive words and
//   assembles them into one wide value for register writeback.
//   Timing from the accept edge: one memory word per cycle.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   cmd_valid/ready command handshake; ready is high only while idle
//   cmd_store       1 = store, 0 = load
//   cmd_addr        base word address
//   cmd_reg         destination register index for a load
//   store_data      register contents for a store, captured at accept
//   mem_addr        memory word address
//   mem_wdata       memory write data
//   mem_we, mem_re  memory write / read strobes
//   mem_rdata       read data, valid the cycle after mem_re
//   load_valid      one-cycle writeback pulse for a completed load
//   load_reg        destination register of the completed load
//   load_data       assembled load result, word i in bits [i*WORD_W +: WORD_W]
//   done            one-cycle pulse at the end of every accepted command
//   err             pulses with done when the base address was out of range
module lsu_burst_engine #(
  parameter int WORDS     = 16,
  parameter int WORD_W    = 32,
  parameter int ADDR_W    = 9,
  parameter int MEM_DEPTH = 512,
  parameter int REG_SEL_W = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_store,
  input  logic [ADDR_W-1:0]         cmd_addr,
  input  logic [REG_SEL_W-1:0]      cmd_reg,
  input  logic [WORDS*WORD_W-1:0]   store_data,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [WORD_W-1:0]         mem_wdata,
  output logic                      mem_we,
  output logic                      mem_re,
  input  logic [WORD_W-1:0]         mem_rdata,
  output logic                      load_valid,
  output logic [REG_SEL_W-1:0]      load_reg,
  output logic [WORDS*WORD_W-1:0]   load_data,
  output logic                      done,
  output logic                      err
);

  localparam int CNT_W = $clog2(WORDS);
  // Highest base address whose whole burst still fits in memory.
  localparam logic [ADDR_W:0] LAST_BASE = (ADDR_W+1)'(MEM_DEPTH - WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STORE,
    S_LOAD,
    S_LOAD_TAIL,
    S_DONE
  } state_t;

  state_t                    state_reg;
  state_t                    state_next;
  logic [CNT_W-1:0]          cnt_reg;
  logic [ADDR_W-1:0]         base_reg;
  logic                      store_reg;
  logic                      err_reg;
  logic [REG_SEL_W-1:0]      reg_sel_reg;
  logic [WORDS*WORD_W-1:0]   data_reg;
  logic [WORDS*WORD_W-1:0]   load_data_reg;

  logic                      accept;
  logic                      range_bad;
  logic                      last_word;
  logic                      cap_en;
  logic [CNT_W-1:0]          cap_idx;
  logic [WORD_W-1:0]         data_words [WORDS];

  // Word view of the latched store register so the counter can index it.
  generate
    for (genvar gi = 0; gi < WORDS; gi++) begin : g_words
      assign data_words[gi] = data_reg[gi*WORD_W +: WORD_W];
    end
  endgenerate

  assign range_bad = ({1'b0, cmd_addr} > LAST_BASE);
  assign accept    = cmd_valid && cmd_ready;
  assign last_word = (cnt_reg == CNT_W'(WORDS - 1));

  // Read data lags the strobe by one cycle, so LOAD cycle i captures word
  // i-1 and the tail cycle captures the final word.
  assign cap_en  = ((state_reg == S_LOAD) && (cnt_reg != '0)) || (state_reg == S_LOAD_TAIL);
  assign cap_idx = (state_reg == S_LOAD_TAIL) ? '1 : (cnt_reg - CNT_W'(1));

  assign load_data = rst ? '0 : load_data_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cmd_ready  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    load_valid = 1'b0;
    load_reg   = '0;
    done       = 1'b0;
    err        = 1'b0;
    case (state_reg)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (range_bad) begin
            state_next = S_DONE;
          end else if (cmd_store) begin
            state_next = S_STORE;
          end else begin
            state_next = S_LOAD;
          end
        end
      end
      S_STORE: begin
        mem_we    = 1'b1;
        mem_addr  = base_reg + ADDR_W'(cnt_reg);
        mem_wdata = data_words[cnt_reg];
        if (last_word) begin
          state_next = S_DONE;
        end
      end
      S_LOAD: begin
        mem_re   = 1'b1;
        mem_addr = base_reg + ADDR_W'(cnt_reg);
        if (last_word) begin
          state_next = S_LOAD_TAIL;
        end
      end
      S_LOAD_TAIL: begin
        state_next = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        err  = err_reg;
        if (!store_reg && !err_reg) begin
          load_valid = 1'b1;
          load_reg   = reg_sel_reg;
        end
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
    // Reset forces every output to its idle value in the same cycle, so an
    // aborted burst issues no further memory strobe.
    if (rst) begin
      state_next = S_IDLE;
      cmd_ready  = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      mem_we     = 1'b0;
      mem_re     = 1'b0;
      load_valid = 1'b0;
      load_reg   = '0;
      done       = 1'b0;
      err        = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg       <= '0;
      base_reg      <= '0;
      store_reg     <= 1'b0;
      err_reg       <= 1'b0;
      reg_sel_reg   <= '0;
      data_reg      <= '0;
      load_data_reg <= '0;
    end else begin
      if (accept) begin
        cnt_reg     <= '0;
        base_reg    <= cmd_addr;
        store_reg   <= cmd_store;
        err_reg     <= range_bad;
        reg_sel_reg <= cmd_reg;
        data_reg    <= store_data;
      end else if ((state_reg == S_STORE) || (state_reg == S_LOAD)) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
      // Words are overwritten only as a new load captures them; the result
      // of the previous load stays visible until then.
      for (int i = 0; i < WORDS; i++) begin
        if (cap_en && (cap_idx == CNT_W'(i))) begin
          load_data_reg[i*WORD_W +: WORD_W] <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_lsu_burst_engine.sv
// Testbench for lsu_burst_engine: a data memory, a transaction-level model
// that expands each accepted command into its expected per-cycle outputs,
// directed scenarios with literal expectations, then randomized commands.
module tb_lsu_burst_engine;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic         cmd_store = 1'b0;
  logic [8:0]   cmd_addr = '0;
  logic [1:0]   cmd_reg = '0;
  logic [511:0] store_data = '0;
  logic [8:0]   mem_addr;
  logic [31:0]  mem_wdata;
  logic         mem_we;
  logic         mem_re;
  logic [31:0]  mem_rdata = '0;
  logic         load_valid;
  logic [1:0]   load_reg;
  logic [511:0] load_data;
  logic         done;
  logic         err;

  lsu_burst_engine dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_store  (cmd_store),
    .cmd_addr   (cmd_addr),
    .cmd_reg    (cmd_reg),
    .store_data (store_data),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .mem_rdata  (mem_rdata),
    .load_valid (load_valid),
    .load_reg   (load_reg),
    .load_data  (load_data),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Expected outputs for one cycle.
  typedef struct packed {
    logic        we;
    logic        re;
    logic        done;
    logic        err;
    logic        lv;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic [1:0]  lreg;
    logic [8:0]  lbase;
  } rec_t;

  rec_t        q[$];
  int          acc_log[$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] mem     [512];
  logic [31:0] mdl_mem [512];
  logic [31:0] init_mem[512];
  int          done_cyc = -1;
  int          lv_cyc = -1;
  int          err_cyc = -1;
  logic [511:0] lv_data = '0;
  logic [1:0]   lv_reg = '0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin
      init_mem[i] = $urandom;
      mem[i]      = init_mem[i];
      mdl_mem[i]  = init_mem[i];
    end
  end

  // Data memory: one-cycle registered read.
  always @(posedge clk) begin
    if (mem_re) mem_rdata <= mem[mem_addr];
    if (mem_we) mem[mem_addr] = mem_wdata;
  end

  // Model: expands an accepted command into its cycle-by-cycle expectation.
  // Cycle k after the accept edge sees cyc == accept_cyc + k - 1.
  always @(posedge clk) begin
    rec_t r;
    cyc++;
    if (rst) begin
      q.delete();
    end else if (q.size() != 0) begin
      r = q.pop_front();
      if (r.we) mdl_mem[r.addr] = r.wdata;
    end else if (cmd_valid) begin
      acc_log.push_back(cyc);
      if (int'(cmd_addr) > 512 - 16) begin
        r = '0; r.done = 1'b1; r.err = 1'b1;
        q.push_back(r);
      end else if (cmd_store) begin
        for (int i = 0; i < 16; i++) begin
          r = '0; r.we = 1'b1; r.addr = cmd_addr + 9'(i);
          r.wdata = store_data[i*32 +: 32];
          q.push_back(r);
        end
        r = '0; r.done = 1'b1;
        q.push_back(r);
      end else begin
        for (int i = 0; i < 16; i++) begin
          r = '0; r.re = 1'b1; r.addr = cmd_addr + 9'(i);
          q.push_back(r);
        end
        r = '0;
        q.push_back(r);
        r = '0; r.done = 1'b1; r.lv = 1'b1; r.lreg = cmd_reg; r.lbase = cmd_addr;
        q.push_back(r);
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    rec_t r;
    logic exp_ready;
    logic [511:0] exp_ld;
    if (rst) begin
      r = '0; exp_ready = 1'b0;
    end else if (q.size() != 0) begin
      r = q[0]; exp_ready = 1'b0;
    end else begin
      r = '0; exp_ready = 1'b1;
    end
    chk("ctrl{ready,we,re,done,err,lv}", 512'({cmd_ready, mem_we, mem_re, done, err, load_valid}),
        512'({exp_ready, r.we, r.re, r.done, r.err, r.lv}));
    if (r.we || r.re) chk("mem_addr", 512'(mem_addr), 512'(r.addr));
    if (r.we) chk("mem_wdata", 512'(mem_wdata), 512'(r.wdata));
    if (r.lv) begin
      for (int i = 0; i < 16; i++) exp_ld[i*32 +: 32] = mdl_mem[int'(r.lbase) + i];
      chk("load_reg", 512'(load_reg), 512'(r.lreg));
      chk("load_data", load_data, exp_ld);
    end
    if (rst) chk("load_data_in_reset", load_data, '0);
    if (done) done_cyc = cyc;
    if (err) err_cyc = cyc;
    if (load_valid) begin
      lv_cyc = cyc; lv_data = load_data; lv_reg = load_reg;
    end
  end

  task automatic issue(input logic st, input logic [8:0] a, input logic [1:0] rg, input logic [511:0] d);
    int t = 0;
    while (!cmd_ready && t < 100) begin
      @(negedge clk); #1; t++;
    end
    if (t >= 100) chk("ready_timeout", 512'(cmd_ready), 512'(1));
    cmd_valid = 1'b1; cmd_store = st; cmd_addr = a; cmd_reg = rg; store_data = d;
    @(negedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (q.size() != 0 && t < 60) begin
      @(negedge clk); #1; t++;
    end
    if (t >= 60) chk("idle_timeout", 512'(q.size()), 512'(0));
    @(negedge clk); #1;
  endtask

  initial begin
    logic [511:0] d;
    logic [511:0] lit;
    int a0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;

    // Store A5A50000+i at 0x000.
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = 32'hA5A50000 + 32'(i);
    issue(1'b1, 9'h000, 2'd0, d);
    wait_idle();
    a0 = acc_log[$];
    chk("store_done_latency", 512'(done_cyc - a0), 512'(16));
    chk("mem_0x000", 512'(mem[0]), 512'(32'hA5A50000));
    chk("mem_0x00F", 512'(mem[15]), 512'(32'hA5A5000F));
    chk("mem_0x010_untouched", 512'(mem[16]), 512'(init_mem[16]));
    $display("store base=000 done");

    // Load back into register 2.
    issue(1'b0, 9'h000, 2'd2, '0);
    wait_idle();
    a0 = acc_log[$];
    for (int i = 0; i < 16; i++) lit[i*32 +: 32] = 32'hA5A50000 + 32'(i);
    chk("load_lv_latency", 512'(lv_cyc - a0), 512'(17));
    chk("load_reg_lit", 512'(lv_reg), 512'(2));
    chk("load_data_lit", lv_data, lit);
    $display("load base=000 reg=2 done");

    // All ones at 0x032.
    issue(1'b1, 9'h032, 2'd0, '1);
    wait_idle();
    issue(1'b0, 9'h032, 2'd1, '0);
    wait_idle();
    chk("mem_0x032", 512'(mem[9'h032]), 512'(32'hFFFFFFFF));
    chk("mem_0x041", 512'(mem[9'h041]), 512'(32'hFFFFFFFF));
    chk("mem_0x031_untouched", 512'(mem[9'h031]), 512'(init_mem[9'h031]));
    chk("mem_0x042_untouched", 512'(mem[9'h042]), 512'(init_mem[9'h042]));
    chk("load_all_ones", lv_data, {512{1'b1}});
    $display("store/load all-ones base=032 done");

    // Range boundary.
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
    issue(1'b1, 9'h1F0, 2'd0, d);
    wait_idle();
    chk("mem_0x1FF", 512'(mem[9'h1FF]), 512'(d[15*32 +: 32]));
    issue(1'b1, 9'h1F1, 2'd0, d);
    wait_idle();
    chk("err_latency", 512'(err_cyc - acc_log[$]), 512'(0));
    issue(1'b0, 9'h1F1, 2'd3, '0);
    wait_idle();
    $display("range checks base=1F0/1F1 done");

    // Back-pressure: cmd_valid held high across two commands.
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
    cmd_valid = 1'b1; cmd_store = 1'b1; cmd_addr = 9'h080; cmd_reg = 2'd0; store_data = d;
    repeat (25) @(negedge clk);
    #1 cmd_valid = 1'b0;
    wait_idle();
    chk("backpressure_spacing", 512'(acc_log[$] - acc_log[$-1]), 512'(18));
    $display("back-pressure accepts spaced %0d", acc_log[$] - acc_log[$-1]);

    // Reset during store cycle 6: words base..base+4 land, nothing after.
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
    done_cyc = -1;
    issue(1'b1, 9'h100, 2'd0, d);
    repeat (5) @(negedge clk);
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    #1 chk("ready_after_rst", 512'(cmd_ready), 512'(1));
    chk("no_done_after_abort", 512'(done_cyc), 512'(-1));
    chk("mem_base+4", 512'(mem[9'h104]), 512'(d[4*32 +: 32]));
    chk("mem_base+5_untouched", 512'(mem[9'h105]), 512'(init_mem[9'h105]));
    $display("reset mid-store base=100 done");
    @(negedge clk); #1;

    // Randomized commands.
    for (int n = 0; n < 40; n++) begin
      logic st;
      logic [8:0] a;
      logic [1:0] rg;
      repeat ($urandom_range(0, 3)) begin @(negedge clk); #1; end
      st = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 4) == 0) ? 9'($urandom_range(497, 511)) : 9'($urandom_range(0, 496));
      rg = 2'($urandom_range(0, 3));
      for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
      issue(st, a, rg, d);
      wait_idle();
      $display("rand %0d: %s addr=%h reg=%0d", n, st ? "store" : "load", a, rg);
    end

    for (int i = 0; i < 512; i++) chk("final_mem", 512'(mem[i]), 512'(mdl_mem[i]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
